// File: rtl/rk_spi_pkg.sv
// rtl/rk_spi_pkg.sv - shared constants, FSM encoding and helpers for rk_spi_master
//
// Purpose: register addresses, cfg/status bit positions, FSM state type and a
//          byte bit-reversal helper used for LSB-first framing.
// Ports:   none (package).
package rk_spi_pkg;

    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_CTRL = 2'd1;
    localparam logic [1:0] REG_DIV  = 2'd2;
    localparam logic [1:0] REG_CFG  = 2'd3;

    localparam int CFG_CPHA = 0;
    localparam int CFG_CPOL = 1;
    localparam int CFG_LSB  = 2;
    localparam int CFG_AUTO = 3;

    localparam int STAT_BUSY = 7;
    localparam int STAT_OVR  = 6;
    localparam int STAT_LOCK = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } spi_state_e;

    function automatic logic [7:0] bit_rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/rk_spi_clkgen.sv
// rtl/rk_spi_clkgen.sv - SCK timing: half-period counter and 16-edge counter
//
// Purpose: while run_i is high, counts 0..div_i clk per half period and emits
//          one strobe per SCK edge. Even edges are leading, odd are trailing.
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   run_i             transfer active; low holds both counters at zero
//   div_i             half-period minus one, in clk cycles
//   lead_o / trail_o  one-clk strobe on a leading / trailing SCK edge
//   last_edge_o       one-clk strobe on edge 15 (final trailing edge)
module rk_spi_clkgen #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             lead_o,
    output logic             trail_o,
    output logic             last_edge_o
);

    logic [DIV_W-1:0] cnt_q;
    logic [3:0]       edge_q;
    logic             tick;

    assign tick = run_i && (cnt_q == div_i);

    // Counters rest at zero outside a transfer, so every start (and every
    // restart after an abort) begins a fresh half period at edge 0.
    always_ff @(posedge clk) begin
        if (reset || !run_i) begin
            cnt_q  <= '0;
            edge_q <= '0;
        end else if (tick) begin
            cnt_q  <= '0;
            edge_q <= edge_q + 4'd1;
        end else begin
            cnt_q  <= cnt_q + 1'b1;
        end
    end

    assign lead_o      = tick && !edge_q[0];
    assign trail_o     = tick &&  edge_q[0];
    assign last_edge_o = tick && (edge_q == 4'd15);

endmodule

// File: rtl/rk_spi_master.sv
// rtl/rk_spi_master.sv - CPU-bus-mapped SPI master for the RK86 0xA000 window
//
// Purpose: register file, strobe edge detectors, transfer FSM and shift
//          registers. One byte per addr0 write (or addr0 read with AUTO).
// Ports:
//   clk, reset                 system clock, synchronous active-high reset
//   addr, idata, we_n, rd_n    CPU register bus (level strobes, active low)
//   odata                      combinational read mux on addr
//   lock                       loader owns the pins: abort and block transfers
//   spi_sck/mosi/miso/cs_n     SPI pins
//   busy, done                 transfer in progress / one-clk completion pulse
module rk_spi_master
    import rk_spi_pkg::*;
#(
    parameter int NUM_CS      = 2,
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        addr,
    input  logic [7:0]        idata,
    input  logic              we_n,
    input  logic              rd_n,
    output logic [7:0]        odata,
    input  logic              lock,
    output logic              spi_sck,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic [NUM_CS-1:0] spi_cs_n,
    output logic              busy,
    output logic              done
);

    spi_state_e        state_q;
    logic [7:0]        rx_q;
    logic [7:0]        tx_q;
    logic [7:0]        rsh_q;
    logic [7:0]        cfg_q;
    logic [DIV_W-1:0]  div_q;
    logic [NUM_CS-1:0] cs_q;
    logic              ovr_q;
    logic              sck_q;
    logic              mosi_q;
    logic              busy_q;
    logic              done_q;
    logic              we_prev_q;
    logic              rd_prev_q;

    logic       we_edge, rd_edge, data_wr, auto_rd, idle, start;
    logic       cpha, cpol, lsb;
    logic [7:0] start_byte, load_byte, rsh_d, stat_rd, div_rd;
    logic       lead, trail, last_edge, sample, shift;

    assign cpha = cfg_q[CFG_CPHA];
    assign cpol = cfg_q[CFG_CPOL];
    assign lsb  = cfg_q[CFG_LSB];

    // A strobe acts only in the clk where it first goes low.
    assign we_edge = !we_n && we_prev_q;
    assign rd_edge = !rd_n && rd_prev_q;

    assign data_wr = we_edge && (addr == REG_DATA);
    assign auto_rd = rd_edge && (addr == REG_DATA) && cfg_q[CFG_AUTO];
    assign idle    = (state_q == ST_IDLE);
    assign start   = idle && !lock && (data_wr || auto_rd);

    // AUTO reads clock out all-ones so the slave sees an idle line.
    assign start_byte = data_wr ? idata : 8'hFF;
    assign load_byte  = lsb ? bit_rev8(start_byte) : start_byte;

    rk_spi_clkgen #(.DIV_W(DIV_W)) u_clkgen (
        .clk         (clk),
        .reset       (reset),
        .run_i       (state_q == ST_XFER),
        .div_i       (div_q),
        .lead_o      (lead),
        .trail_o     (trail),
        .last_edge_o (last_edge)
    );

    assign sample = cpha ? trail : lead;
    // CPHA=0 presents bit 7 at entry, so the final trailing edge has nothing
    // left to shift; CPHA=1 presents each bit on its leading edge.
    assign shift  = cpha ? lead : (trail && !last_edge);

    // The sample taken on the final edge must reach rx in the same clk.
    assign rsh_d = sample ? {rsh_q[6:0], spi_miso} : rsh_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            rx_q      <= 8'hFF;
            tx_q      <= '0;
            rsh_q     <= '0;
            cfg_q     <= '0;
            div_q     <= DIV_W'(DEFAULT_DIV);
            cs_q      <= '0;
            ovr_q     <= 1'b0;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            we_prev_q <= 1'b1;
            rd_prev_q <= 1'b1;
        end else begin
            we_prev_q <= we_n;
            rd_prev_q <= rd_n;
            done_q    <= 1'b0;

            if (we_edge && (addr == REG_CTRL)) begin
                cs_q <= idata[NUM_CS-1:0];
                if (idata[STAT_OVR]) begin
                    ovr_q <= 1'b0;
                end
            end
            // Outside IDLE (including the DONE clk) a data write cannot start.
            if (data_wr && !idle) begin
                ovr_q <= 1'b1;
            end
            if (we_edge && idle) begin
                if (addr == REG_DIV) begin
                    div_q <= idata[DIV_W-1:0];
                end
                if (addr == REG_CFG) begin
                    cfg_q <= {4'b0000, idata[3:0]};
                end
            end

            case (state_q)
                ST_IDLE: begin
                    sck_q  <= cpol;
                    mosi_q <= 1'b1;
                    busy_q <= 1'b0;
                    if (start) begin
                        state_q <= ST_XFER;
                        busy_q  <= 1'b1;
                        rsh_q   <= '0;
                        tx_q    <= load_byte;
                        if (!cpha) begin
                            mosi_q <= load_byte[7];
                            tx_q   <= {load_byte[6:0], 1'b0};
                        end
                    end
                end
                ST_XFER: begin
                    if (lock) begin
                        state_q <= ST_IDLE;
                        sck_q   <= cpol;
                        mosi_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        rsh_q <= rsh_d;
                        if (lead || trail) begin
                            sck_q <= ~sck_q;
                        end
                        if (shift) begin
                            mosi_q <= tx_q[7];
                            tx_q   <= {tx_q[6:0], 1'b0};
                        end
                        if (last_edge) begin
                            state_q <= ST_DONE;
                            rx_q    <= lsb ? bit_rev8(rsh_d) : rsh_d;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            mosi_q  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        stat_rd              = '0;
        stat_rd[NUM_CS-1:0]  = cs_q;
        stat_rd[STAT_BUSY]   = busy_q;
        stat_rd[STAT_OVR]    = ovr_q;
        stat_rd[STAT_LOCK]   = lock;
        div_rd               = '0;
        div_rd[DIV_W-1:0]    = div_q;
    end

    always_comb begin
        odata = rx_q;
        case (addr)
            REG_DATA: odata = rx_q;
            REG_CTRL: odata = stat_rd;
            REG_DIV:  odata = div_rd;
            REG_CFG:  odata = cfg_q;
            default:  odata = rx_q;
        endcase
    end

    assign spi_cs_n = lock ? '1 : ~cs_q;
    assign spi_sck  = sck_q;
    assign spi_mosi = mosi_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_rk_spi_master.sv
// tb/tb_rk_spi_master.sv - self-checking scoreboard bench for rk_spi_master
module tb_rk_spi_master;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] addr = 2'd0;
    logic [7:0] idata = 8'd0;
    logic       we_n = 1'b1;
    logic       rd_n = 1'b1;
    logic [7:0] odata;
    logic       lock = 1'b0;
    logic       spi_sck;
    logic       spi_mosi;
    logic       spi_miso = 1'b1;
    logic [1:0] spi_cs_n;
    logic       busy;
    logic       done;

    rk_spi_master #(.NUM_CS(2), .DIV_W(8), .DEFAULT_DIV(24)) dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .idata    (idata),
        .we_n     (we_n),
        .rd_n     (rd_n),
        .odata    (odata),
        .lock     (lock),
        .spi_sck  (spi_sck),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .spi_cs_n (spi_cs_n),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[7-i] = b[i];
        return r;
    endfunction

    typedef struct {
        logic [7:0] mosi;
        logic [7:0] rx;
    } sb_t;
    sb_t sb_q[$];

    // Slave / monitor state
    logic [7:0] slave_byte = 8'hFF;
    logic       m_cpol = 1'b0;
    logic       m_cpha = 1'b0;
    logic       sck_prev = 1'b0;
    logic       busy_prev = 1'b0;
    logic       mosi_prev = 1'b1;
    logic [7:0] mosi_cap = 8'd0;
    logic [7:0] last_rx_exp = 8'hFF;
    int         sck_edges = 0;
    int         rise_cnt = 0;
    int         busy_cycles = 0;
    int         busy_rises = 0;
    int         done_cnt = 0;

    always @(negedge clk) begin
        sb_t item;
        int  idx;
        if (busy && !busy_prev) begin
            sck_edges  = 0;
            rise_cnt   = 0;
            mosi_cap   = 8'd0;
            busy_cycles = 0;
            busy_rises++;
        end
        if (busy) busy_cycles++;
        if ((busy || busy_prev) && (spi_sck != sck_prev)) begin
            sck_edges++;
            if (spi_sck) rise_cnt++;
            // The slave latches the line value held just before the edge.
            if ((spi_sck != m_cpol) != m_cpha) mosi_cap = {mosi_cap[6:0], mosi_prev};
        end
        if (busy || busy_prev) begin
            idx = m_cpha ? ((sck_edges == 0) ? 0 : (sck_edges - 1) / 2) : sck_edges / 2;
            spi_miso = (idx < 8) ? slave_byte[7-idx] : 1'b1;
        end
        if (done) begin
            done_cnt++;
            chk("sb_nonempty", {31'd0, sb_q.size() != 0}, 32'd1);
            if (sb_q.size() != 0) begin
                item = sb_q.pop_front();
                chk("mosi_byte", {24'd0, mosi_cap}, {24'd0, item.mosi});
                last_rx_exp = item.rx;
            end
        end
        sck_prev  = spi_sck;
        busy_prev = busy;
        mosi_prev = spi_mosi;
    end

    task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a; idata = d; we_n = 1'b0;
        repeat (3) @(negedge clk);
        we_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic cpu_read(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk);
        addr = a; rd_n = 1'b0;
        @(negedge clk);
        d = odata;
        rd_n = 1'b1;
    endtask

    task automatic push_xfer(input logic [7:0] tx, input logic [7:0] slv, input logic lsb);
        sb_t it;
        it.mosi = lsb ? rev8(tx) : tx;
        it.rx   = lsb ? rev8(slv) : slv;
        slave_byte = slv;
        sb_q.push_back(it);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        logic seen = 1'b0;
        while (!seen && k < budget) begin
            @(negedge clk);
            seen = done;
            k++;
        end
        chk(tag, {31'd0, seen}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] rd;
        int d0, b0, k;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_sck", {31'd0, spi_sck}, 32'd0);
        chk("rst_mosi", {31'd0, spi_mosi}, 32'd1);
        chk("rst_cs_n", {30'd0, spi_cs_n}, 32'd3);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        cpu_read(2'd0, rd); chk("rst_rx", {24'd0, rd}, 32'hFF);
        cpu_read(2'd2, rd); chk("rst_div", {24'd0, rd}, 32'd24);
        cpu_read(2'd3, rd); chk("rst_cfg", {24'd0, rd}, 32'd0);
        cpu_read(2'd1, rd); chk("rst_stat", {24'd0, rd}, 32'd0);

        // Mode 0, div=1, cs=01
        cpu_write(2'd1, 8'h01);
        cpu_write(2'd2, 8'd1);
        cpu_write(2'd3, 8'h00);
        m_cpol = 1'b0; m_cpha = 1'b0;
        d0 = done_cnt;
        push_xfer(8'hA5, 8'h3C, 1'b0);
        cpu_write(2'd0, 8'hA5);
        wait_done("m0_done", 200);
        repeat (4) @(negedge clk);
        chk("m0_rises", rise_cnt, 8);
        chk("m0_busy_len", busy_cycles, 32);
        chk("m0_done_cnt", done_cnt - d0, 1);
        cpu_read(2'd0, rd); chk("m0_rx", {24'd0, rd}, {24'd0, last_rx_exp});
        chk("m0_cs_n", {30'd0, spi_cs_n}, 32'd2);

        // Mode 3, LSB-first, div=0
        m_cpol = 1'b1; m_cpha = 1'b1;
        cpu_write(2'd2, 8'd0);
        cpu_write(2'd3, 8'h07);
        @(negedge clk);
        chk("m3_sck_idle", {31'd0, spi_sck}, 32'd1);
        push_xfer(8'h81, 8'h01, 1'b1);
        cpu_write(2'd0, 8'h81);
        wait_done("m3_done", 100);
        chk("m3_busy_len", busy_cycles, 16);
        cpu_read(2'd0, rd); chk("m3_rx", {24'd0, rd}, 32'h80);
        chk("m3_sb_rx", {24'd0, rd}, {24'd0, last_rx_exp});
        chk("m3_sck_end", {31'd0, spi_sck}, 32'd1);

        // Overrun: second write 5 clk into a transfer
        m_cpol = 1'b0; m_cpha = 1'b0;
        cpu_write(2'd3, 8'h00);
        cpu_write(2'd2, 8'd3);
        d0 = done_cnt; b0 = busy_rises;
        push_xfer(8'h5A, 8'h96, 1'b0);
        @(negedge clk); addr = 2'd0; idata = 8'h5A; we_n = 1'b0;
        @(negedge clk); we_n = 1'b1;
        repeat (3) @(negedge clk);
        idata = 8'h33; we_n = 1'b0;
        @(negedge clk); we_n = 1'b1;
        wait_done("ovr_done", 200);
        repeat (6) @(negedge clk);
        chk("ovr_one_xfer", busy_rises - b0, 1);
        cpu_read(2'd0, rd); chk("ovr_rx", {24'd0, rd}, {24'd0, last_rx_exp});
        cpu_read(2'd1, rd); chk("ovr_flag_set", {31'd0, rd[6]}, 32'd1);
        cpu_write(2'd1, 8'h41);
        cpu_read(2'd1, rd); chk("ovr_flag_clr", {24'd0, rd}, 32'h01);

        // Lock at edge 7
        d0 = done_cnt;
        slave_byte = 8'hC3;
        cpu_write(2'd0, 8'hE7);
        k = 0;
        while (sck_edges < 7 && k < 300) begin @(negedge clk); k++; end
        chk("lock_reach_e7", {31'd0, sck_edges >= 7}, 32'd1);
        lock = 1'b1;
        @(negedge clk);
        chk("lock_cs_n", {30'd0, spi_cs_n}, 32'd3);
        chk("lock_sck", {31'd0, spi_sck}, 32'd0);
        chk("lock_busy", {31'd0, busy}, 32'd0);
        repeat (80) @(negedge clk);
        chk("lock_no_done", done_cnt - d0, 0);
        cpu_read(2'd0, rd); chk("lock_rx_kept", {24'd0, rd}, 32'h96);
        cpu_read(2'd1, rd); chk("lock_stat", {24'd0, rd}, 32'h21);
        b0 = busy_rises;
        cpu_write(2'd0, 8'h11);
        repeat (4) @(negedge clk);
        lock = 1'b0;
        repeat (4) @(negedge clk);
        chk("lock_blocked", busy_rises - b0, 0);
        chk("lock_idle_busy", {31'd0, busy}, 32'd0);

        // AUTO read held low 28 clk
        cpu_write(2'd2, 8'd0);
        cpu_write(2'd3, 8'h08);
        d0 = done_cnt; b0 = busy_rises;
        push_xfer(8'hFF, 8'h5A, 1'b0);
        @(negedge clk); addr = 2'd0; rd_n = 1'b0;
        repeat (28) @(negedge clk);
        rd_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("auto_one_xfer", busy_rises - b0, 1);
        chk("auto_done_cnt", done_cnt - d0, 1);
        push_xfer(8'hFF, 8'h5A, 1'b0);
        cpu_read(2'd0, rd); chk("auto_rx", {24'd0, rd}, 32'h5A);
        wait_done("auto2_done", 60);
        cpu_write(2'd3, 8'h00);

        // Reset mid-transfer
        m_cpol = 1'b1; m_cpha = 1'b0;
        cpu_write(2'd3, 8'h02);
        cpu_write(2'd2, 8'd2);
        slave_byte = 8'h00;
        cpu_write(2'd0, 8'hF0);
        repeat (6) @(negedge clk);
        chk("mid_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("mr_sck", {31'd0, spi_sck}, 32'd0);
        chk("mr_mosi", {31'd0, spi_mosi}, 32'd1);
        chk("mr_cs_n", {30'd0, spi_cs_n}, 32'd3);
        chk("mr_busy", {31'd0, busy}, 32'd0);
        chk("mr_done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        m_cpol = 1'b0;
        cpu_read(2'd2, rd); chk("mr_div", {24'd0, rd}, 32'd24);
        cpu_read(2'd0, rd); chk("mr_rx", {24'd0, rd}, 32'hFF);
        cpu_read(2'd3, rd); chk("mr_cfg", {24'd0, rd}, 32'd0);
        repeat (10) @(negedge clk);
        chk("sb_drained", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rk_spi_master.md
Name: rk_spi_master

Overview:
CPU-bus-mapped SPI master for the RK86 core. It replaces the bit-banged SD port in the 0xA000 window: the CPU writes a byte and the hardware shifts it out and in. The divider and SPI mode are programmable, chip-select lines are parametrised, and an optional auto-transfer on read is provided. It sits between the k580 bus decode and the shared DCLK/ASDO/DATA0 pins. The `lock` input yields those pins to the flash loader.

Parameters:
- NUM_CS, 2, number of chip-select outputs (1..4).
- DIV_W, 8, width of the SCK divider register.
- DEFAULT_DIV, 24, divider value after reset. Half-period is DIV+1 clk cycles.

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  synchronous, active-high reset.
- addr  in  2  register select (addrbus[1:0]).
- idata  in  8  CPU write data.
- we_n  in  1  write strobe, active low, level (held for many clk).
- rd_n  in  1  read strobe, active low, level.
- odata  out  8  register read data (combinational mux on addr).
- lock  in  1  pins owned by loader; aborts and blocks transfers.
- spi_sck  out  1  serial clock.
- spi_mosi  out  1  serial data out.
- spi_miso  in  1  serial data in.
- spi_cs_n  out  NUM_CS  chip selects, active low.
- busy  out  1  transfer in progress.
- done  out  1  one-clk pulse at end of each completed transfer.

Behaviour:
- Reset is synchronous and active-high. Reset values:
  - spi_sck=0, spi_mosi=1, spi_cs_n=all 1, busy=0, done=0.
  - rx=0xFF, div=DEFAULT_DIV, cfg=0, cs_reg=0, overrun=0.
- Strobes are edge-detected. A write acts only in the clk where we_n=0 and was 1 in the previous clk. Reads are detected the same way on rd_n. Holding a strobe low has no further effect.
- Register map:
  - addr0 W: start a transfer of idata. addr0 R: last received byte.
  - addr1 W: [NUM_CS-1:0] cs_reg (1 = asserted); [6]=1 clears overrun.
  - addr1 R: [7] busy, [6] overrun, [5] lock, [NUM_CS-1:0] cs_reg; unused bits read 0.
  - addr2 RW: div (upper bits beyond DIV_W read 0).
  - addr3 RW: cfg[0] CPHA, [1] CPOL, [2] LSB-first, [3] AUTO; other bits read 0.
- Chip selects: spi_cs_n = ~cs_reg when lock=0, else all 1.
- Idle sck: when idle, spi_sck follows CPOL.
- FSM states: IDLE, XFER, DONE.
- IDLE → XFER on an addr0 write edge, or on an addr0 read edge when AUTO=1 (shifts 0xFF). The transition requires lock=0.
  - Load the shift register (bit-reversed if LSB-first). Clear the half-period counter and edge counter. Set busy=1.
  - CPHA=0: spi_mosi = first bit in the same clk as the XFER entry.
- XFER: the half-period counter counts 0..div. At terminal count it wraps to 0, toggles sck and increments the edge counter (0..15).
  - Even edges are leading edges, odd edges are trailing edges.
  - CPHA=0: sample miso on leading edges, shift mosi on trailing edges except the last.
  - CPHA=1: shift mosi on leading edges (first leading edge presents bit 7), sample on trailing edges.
  - After edge 15: go to DONE, with sck back at CPOL.
- Transfer length: exactly 16×(div+1) clk from the start edge to DONE.
- DONE, one clk: rx ← assembled byte (un-reversed if LSB-first); done=1; busy=0; mosi=1; → IDLE.
- An addr0 write while busy is ignored and sets overrun (sticky). An AUTO read while busy only returns rx, with no overrun.
- Writes to addr2/addr3 while busy are ignored. Writes to addr1 are accepted at any time, so cs changes take effect immediately.
- lock=1 in XFER forces the next state to IDLE. sck=CPOL, mosi=1, busy=0, no done pulse, rx unchanged.
- Simultaneous DONE and a new addr0 write edge: the write is accepted as an IDLE start in the next clk only if the strobe edge is still pending. It is not pending, so the write is treated as busy → overrun.
- div=0 gives a half-period of 1 clk, i.e. a 25 MHz SCK.

Decomposition:
- Shared package `rk_spi_pkg`: register address constants (REG_DATA=0, REG_CTRL=1, REG_DIV=2, REG_CFG=3), cfg bit indices, FSM state encoding.
- One sub-module, `rk_spi_clkgen`: half-period counter plus edge counter, emitting lead/trail strobes and last_edge.
- Top level holds the register file, the strobe edge detectors, the FSM and the shift register.

Test Plan:
- Mode 0, div=1, cs_reg=01:
  - Write 0xA5; slave model returns 0x3C.
  - Expect 8 rising sck edges, mosi bits 1,0,1,0,0,1,0,1, busy high for 32 clk and one done pulse.
  - addr0 read = 0x3C; spi_cs_n=10.
- Mode 3 (CPOL=1, CPHA=1) with LSB-first and div=0:
  - Write 0x81; slave returns 0x01.
  - Expect sck idle high, 16 clk transfer, mosi first bit 1, rx=0x80.
- A second addr0 write 5 clk into a transfer → first byte completes unchanged and status[6]=1. Writing 0x40 to addr1 clears it.
- Assert lock at edge 7 of a transfer → cs_n all 1, sck=CPOL, busy=0 in the next clk, no done, rx keeps its old value. A write while lock=1 leaves the FSM in IDLE.
- AUTO=1, addr0 read strobe held low for 28 clk → exactly one transfer, mosi constant 1, and the new rx is visible on the next read.
- Reset asserted mid-transfer → all outputs take their reset values in the next clk and div reads back 24.
